// File: rtl/ram_clr_pkg.sv
// ram_clr_pkg: shared definitions for the clearable RAM family.
//   ram_state_e       - clear-sequencer state encoding (CLEAR=0, READY=1)
//   DEFAULT_WIDTH     - default word width, also used by CPU / memory-map blocks
//   DEFAULT_ADDR_BITS - default address width (DEPTH = 2**ADDR_BITS)
package ram_clr_pkg;

  typedef enum logic {
    RAM_ST_CLEAR = 1'b0,
    RAM_ST_READY = 1'b1
  } ram_state_e;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_ADDR_BITS = 9;

endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: walks a pointer over every word after reset, asking the
// storage array to write zero at each one, then parks in READY.
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; restarts the clear from word 0
//   clr_we   out  request to write zero this edge
//   clr_addr out  word to zero this edge
//   ready    out  1 once every word has been zeroed
//   state    out  current sequencer state (debug visibility)
module ram_clear_fsm
  import ram_clr_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr,
  output logic                 ready,
  output ram_state_e           state
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  // The pointer carries one extra bit so the last word can be compared
  // without relying on wrap-around.
  localparam logic [ADDR_BITS:0] LAST_PTR = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [ADDR_BITS:0] PTR_ONE  = (ADDR_BITS+1)'(1);

  ram_state_e           state_q, state_d;
  logic [ADDR_BITS:0]   ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RAM_ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we   = 1'b0;
    clr_addr = ptr_q[ADDR_BITS-1:0];
    if (reset) begin
      // The reset edge itself zeroes word 0, whatever state we were in.
      clr_we   = 1'b1;
      clr_addr = '0;
    end else begin
      case (state_q)
        RAM_ST_CLEAR: begin
          clr_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
          if (ptr_q == LAST_PTR) begin
            state_d = RAM_ST_READY;
          end
        end
        RAM_ST_READY: begin
          state_d = RAM_ST_READY;
        end
        default: begin
          state_d = RAM_ST_CLEAR;
        end
      endcase
    end
  end

  assign ready = (state_q == RAM_ST_READY);
  assign state = state_q;

endmodule

// File: rtl/ram_clr.sv
// ram_clr: word-addressed RAM with a read/write port A, a read-only port B,
// and a built-in clear sequence that zeroes every word after reset.
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high; (re)starts the clear sequence
//   load      in   port A write enable (ignored while clearing)
//   address   in   port A read/write address
//   in        in   port A write data
//   out       out  port A read data, combinational, 0 while clearing
//   address_b in   port B read address
//   out_b     out  port B read data, combinational, 0 while clearing
//   ready     out  high once the clear sequence has completed
//
// Handshake: ready is the only flow control. A write with load=1 is taken at
// a rising edge only when ready=1 before that edge; while ready=0 the user
// must hold load low or accept that the write is discarded.
module ram_clr
  import ram_clr_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out,
  input  logic [ADDR_BITS-1:0] address_b,
  output logic [WIDTH-1:0]     out_b,
  output logic                 ready
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_addr;
  ram_state_e           seq_state;

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_open;

  ram_clear_fsm #(
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready),
    .state    (seq_state)
  );

  // The sequencer owns the write port whenever it asks for it; user writes
  // only get through once it has finished.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (load) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads are straight from the array (no write bypass), so a same-address
  // write shows the old word until the edge. Partially cleared contents are
  // hidden behind a zero-force until the sequence completes.
  assign rd_open = (seq_state == RAM_ST_READY);
  assign out     = rd_open ? mem[address]   : '0;
  assign out_b   = rd_open ? mem[address_b] : '0;

endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: self-checking bench for ram_clr. Uses a small instance
// (WIDTH=16, ADDR_BITS=3) for the functional plan and a default-parameter
// instance (WIDTH=16, ADDR_BITS=9) for the full-depth clear and end words.
module tb_ram_clr;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance signals
  logic        s_reset = 1'b0;
  logic        s_load  = 1'b0;
  logic [2:0]  s_addr  = '0;
  logic [15:0] s_in    = '0;
  logic [2:0]  s_addr_b = '0;
  logic [15:0] s_out, s_out_b;
  logic        s_ready;

  // default instance signals
  logic        b_reset = 1'b0;
  logic        b_load  = 1'b0;
  logic [8:0]  b_addr  = '0;
  logic [15:0] b_in    = '0;
  logic [8:0]  b_addr_b = '0;
  logic [15:0] b_out, b_out_b;
  logic        b_ready;

  ram_clr #(.WIDTH(16), .ADDR_BITS(3)) u_small (
    .clk       (clk),
    .reset     (s_reset),
    .load      (s_load),
    .address   (s_addr),
    .in        (s_in),
    .out       (s_out),
    .address_b (s_addr_b),
    .out_b     (s_out_b),
    .ready     (s_ready)
  );

  ram_clr u_big (
    .clk       (clk),
    .reset     (b_reset),
    .load      (b_load),
    .address   (b_addr),
    .in        (b_in),
    .out       (b_out),
    .address_b (b_addr_b),
    .out_b     (b_out_b),
    .ready     (b_ready)
  );

  // ---------------- reference model (small instance) ----------------
  // Behavioural view: after reset the memory is all zero but invisible for
  // 8 edges; after that it is an ordinary RAM.
  logic [15:0] m_mem [8];
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (s_reset) begin
      m_cnt <= 0;
      for (int i = 0; i < 8; i++) m_mem[i] <= '0;
    end else if (m_cnt < 8) begin
      m_cnt <= m_cnt + 1;
    end else if (s_load) begin
      m_mem[s_addr] <= s_in;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic small_read_all_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      s_addr   = 3'(i);
      s_addr_b = 3'(7 - i);
      tick();
      check({name, "_out"},   {16'h0, s_out},   32'h0);
      check({name, "_out_b"}, {16'h0, s_out_b}, 32'h0);
    end
  endtask

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [2:0]  addr_b;
    logic [15:0] exp_out;
    logic [15:0] exp_out_b;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int edges;

    // Table: inputs applied, outputs checked before the edge, then clocked.
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 3'd7, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 3'd7, 16'hBEEF, 3'd3, 16'h0000, 16'h1234, 1'b1};
    vecs[2] = '{1'b0, 3'd3, 16'h0000, 3'd7, 16'h1234, 16'hBEEF, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 3'd5, 16'h0001, 3'd5, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 3'd5, 16'h00FF, 3'd5, 16'h0001, 16'h0001, 1'b1};
    vecs[6] = '{1'b0, 3'd5, 16'h0000, 3'd5, 16'h00FF, 16'h00FF, 1'b1};
    vecs[7] = '{1'b0, 3'd7, 16'h0000, 3'd3, 16'hBEEF, 16'h1234, 1'b1};

    // ---- default parameters: 512-word clear, end words ----
    b_reset = 1'b1;
    tick();
    check("big_reset_ready", {31'h0, b_ready}, 32'h0);
    check("big_reset_out",   {16'h0, b_out},   32'h0);
    b_reset = 1'b0;
    edges = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (b_ready) begin
        edges = k;
        break;
      end
    end
    check("big_ready_edges", edges, 512);
    b_load = 1'b1; b_addr = 9'd511; b_in = 16'h7FFF;
    tick();
    b_addr = 9'd0; b_in = 16'h0002;
    tick();
    b_load = 1'b0; b_addr = 9'd511; b_addr_b = 9'd0;
    #1;
    check("big_out_511",   {16'h0, b_out},   32'h7FFF);
    check("big_out_b_0",   {16'h0, b_out_b}, 32'h0002);
    tick();
    b_addr = 9'd0; b_addr_b = 9'd511;
    #1;
    check("big_out_0",     {16'h0, b_out},   32'h0002);
    check("big_out_b_511", {16'h0, b_out_b}, 32'h7FFF);

    // ---- small: reset/clear with a write attempted throughout ----
    s_reset = 1'b1; s_load = 1'b1; s_addr = 3'd6; s_in = 16'hAAAA; s_addr_b = 3'd6;
    tick();
    check("rst_ready", {31'h0, s_ready}, 32'h0);
    check("rst_out",   {16'h0, s_out},   32'h0);
    check("rst_out_b", {16'h0, s_out_b}, 32'h0);
    s_reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        check("clr_ready_low", {31'h0, s_ready}, 32'h0);
        check("clr_out_zero",  {16'h0, s_out},   32'h0);
      end else begin
        check("clr_ready_high", {31'h0, s_ready}, 32'h1);
        check("clr_dropped_w6", {16'h0, s_out},   32'h0);
      end
    end
    s_load = 1'b0;
    small_read_all_zero("clr_word");

    // ---- small: table of write/read and read-during-write vectors ----
    for (int i = 0; i < 8; i++) begin
      s_load = vecs[i].load; s_addr = vecs[i].addr;
      s_in = vecs[i].din;    s_addr_b = vecs[i].addr_b;
      #1;
      check($sformatf("vec%0d_out", i),   {16'h0, s_out},   {16'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_out_b", i), {16'h0, s_out_b}, {16'h0, vecs[i].exp_out_b});
      check($sformatf("vec%0d_ready", i), {31'h0, s_ready}, {31'h0, vecs[i].exp_ready});
      tick();
    end
    s_load = 1'b0;

    // ---- small: reset after use, then reset again mid-clear ----
    for (int i = 0; i < 8; i++) begin
      s_load = 1'b1; s_addr = 3'(i); s_in = 16'hFFFF;
      tick();
    end
    s_load = 1'b0; s_addr = 3'd2; s_addr_b = 3'd6;
    #1;
    check("fill_out",   {16'h0, s_out},   32'hFFFF);
    check("fill_out_b", {16'h0, s_out_b}, 32'hFFFF);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    tick(); tick(); tick();
    check("midclr_ready", {31'h0, s_ready}, 32'h0);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (s_ready) begin
        edges = k;
        break;
      end
    end
    check("rerun_ready_edges", edges, 8);
    small_read_all_zero("rerun_word");

    // ---- small: random traffic against the reference model ----
    for (int n = 0; n < 400; n++) begin
      s_reset  = ($urandom_range(0, 59) == 0);
      s_load   = 1'($urandom_range(0, 1));
      s_addr   = 3'($urandom_range(0, 7));
      s_addr_b = 3'($urandom_range(0, 7));
      s_in     = 16'($urandom);
      #1;
      exp_q.push_back((m_cnt == 8) ? m_mem[s_addr]   : 16'h0);
      exp_q.push_back((m_cnt == 8) ? m_mem[s_addr_b] : 16'h0);
      check("rnd_out",   {16'h0, s_out},   {16'h0, exp_q.pop_front()});
      check("rnd_out_b", {16'h0, s_out_b}, {16'h0, exp_q.pop_front()});
      check("rnd_ready", {31'h0, s_ready}, (m_cnt == 8) ? 32'h1 : 32'h0);
      tick();
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
